wav_sample_fetcher: RTL and testbench

- Downstream consumer of the HPS file-data stream port (32-bit readdata/read/waitrequest) on the soc_system.
- Acts as an Avalon-MM read master that pulls packed PCM words into a small FIFO.
- Unpacks each word into signed 16-bit left/right samples.
- Presents one sample pair per audio-rate tick to the codec serializer, with underrun detection and counting.

---
 rtl/wav_fetch_pkg.sv | 20 ++
 rtl/wav_sync_fifo.sv | 81 ++++++++
 rtl/wav_sample_fetcher.sv | 214 +++++++++++++++++++++
 tb/tb_wav_sample_fetcher.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wav_fetch_pkg.sv
// Shared types and constants for the WAV sample fetcher.
package wav_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam int          LEFT_LSB     = 0;
  localparam int          RIGHT_LSB    = 16;
  localparam int          SAMPLE_W_DEF = 16;
  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  // Saturating increment for the underrun counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == UNDERRUN_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wav_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear.
// dout always shows the head entry; it is meaningless while empty.
module wav_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [AW:0]  level,
  output logic         empty
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok_s, pop_ok_s;

  // Pointer and occupancy update; clear wins over any same-cycle push/pop.
  always_comb begin
    push_ok_s = push && (level_q != DEPTH_L);
    pop_ok_s  = pop && (level_q != {(AW+1){1'b0}});
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (clear) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_d = level_q + {{AW{1'b0}}, 1'b1};
        2'b01:   level_d = level_q - {{AW{1'b0}}, 1'b1};
        default: level_d = level_q;
      endcase
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; data contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clear) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign empty = (level_q == {(AW+1){1'b0}});

endmodule

// File: rtl/wav_sample_fetcher.sv
// WAV sample fetcher: Avalon-MM read master feeding a word FIFO, unpacked
// into signed 16-bit left/right samples on each audio-rate tick.
// Optional feature macro: WAV_FETCH_MONO_EN (adds mono_mode input; each word
// then carries two mono samples, low half first).
module wav_sample_fetcher
  import wav_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4,
  parameter int SAMPLE_W   = SAMPLE_W_DEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                enable,
  input  logic                flush,
  output logic                file_data_read,
  input  logic [31:0]         file_data_readdata,
  input  logic                file_data_waitrequest,
  input  logic                sample_tick,
`ifdef WAV_FETCH_MONO_EN
  input  logic                mono_mode,
`endif
  output logic [SAMPLE_W-1:0] left_sample,
  output logic [SAMPLE_W-1:0] right_sample,
  output logic                sample_valid,
  output logic                underrun,
  output logic [15:0]         underrun_count,
  output logic [FIFO_AW:0]    fifo_level
);

  localparam logic [FIFO_AW+1:0] DEPTH_L = (FIFO_AW+2)'(FIFO_DEPTH);

  fetch_state_t          state_q, state_d;
  logic                  read_q, read_d;
  logic [SAMPLE_W-1:0]   left_q, left_d;
  logic [SAMPLE_W-1:0]   right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  underrun_q, underrun_d;
  logic [15:0]           ucount_q, ucount_d;

  logic                  xfer_s;
  logic                  push_s;
  logic                  pop_s;
  logic [31:0]           head_s;
  logic [FIFO_AW:0]      level_s;
  logic                  empty_s;
  logic [FIFO_AW+1:0]    fill_next_s;

`ifdef WAV_FETCH_MONO_EN
  logic                  mono_q, mono_d;
  logic                  half_q, half_d;
`endif

  wav_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW),
    .W     (32)
  ) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .clear (flush),
    .push  (push_s),
    .din   (file_data_readdata),
    .pop   (pop_s),
    .dout  (head_s),
    .level (level_s),
    .empty (empty_s)
  );

  assign xfer_s = read_q && !file_data_waitrequest;
  // Occupancy after a completing push plus any same-cycle pop.
  assign fill_next_s = {1'b0, level_s} + {{(FIFO_AW+1){1'b0}}, 1'b1}
                     - {{(FIFO_AW+1){1'b0}}, pop_s};

  // Fetch FSM next state; read is a registered image of "not IDLE next".
  always_comb begin
    state_d = state_q;
    push_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !flush && ({1'b0, level_s} < DEPTH_L)) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (xfer_s) begin
          // A flush landing on the completing cycle drops the word.
          push_s = !flush;
          if (enable && !flush && (fill_next_s < DEPTH_L)) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else if (flush) begin
          state_d = DISCARD;
        end else begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (xfer_s) begin
          state_d = IDLE;
        end else begin
          state_d = DISCARD;
        end
      end
      default: state_d = IDLE;
    endcase
    read_d = (state_d != IDLE);
  end

  // Tick handling: pop/unpack, underrun status, flush clearing.
  always_comb begin
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = 1'b0;
    pop_s      = 1'b0;
    underrun_d = underrun_q;
    ucount_d   = ucount_q;
`ifdef WAV_FETCH_MONO_EN
    half_d     = half_q;
    if (!empty_s || !(level_s == {(FIFO_AW+1){1'b0}} && state_q == IDLE)) begin
      mono_d = mono_q;
    end else begin
      mono_d = mono_mode;
    end
`endif
    if (sample_tick) begin
      valid_d = 1'b1;
      left_d  = {SAMPLE_W{1'b0}};
      right_d = {SAMPLE_W{1'b0}};
      if (enable && !flush) begin
        if (!empty_s) begin
`ifdef WAV_FETCH_MONO_EN
          if (mono_q && !half_q) begin
            left_d  = head_s[LEFT_LSB +: SAMPLE_W];
            right_d = head_s[LEFT_LSB +: SAMPLE_W];
            half_d  = 1'b1;
          end else if (mono_q) begin
            left_d  = head_s[RIGHT_LSB +: SAMPLE_W];
            right_d = head_s[RIGHT_LSB +: SAMPLE_W];
            half_d  = 1'b0;
            pop_s   = 1'b1;
          end else begin
            left_d  = head_s[LEFT_LSB +: SAMPLE_W];
            right_d = head_s[RIGHT_LSB +: SAMPLE_W];
            pop_s   = 1'b1;
          end
`else
          left_d  = head_s[LEFT_LSB +: SAMPLE_W];
          right_d = head_s[RIGHT_LSB +: SAMPLE_W];
          pop_s   = 1'b1;
`endif
        end else begin
          underrun_d = 1'b1;
          ucount_d   = sat_inc16(ucount_q);
        end
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
    end
    if (flush) begin
      underrun_d = 1'b0;
      ucount_d   = 16'd0;
`ifdef WAV_FETCH_MONO_EN
      half_d     = 1'b0;
`endif
    end else begin
      underrun_d = underrun_d;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      left_q     <= {SAMPLE_W{1'b0}};
      right_q    <= {SAMPLE_W{1'b0}};
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      ucount_q   <= 16'd0;
`ifdef WAV_FETCH_MONO_EN
      mono_q     <= 1'b0;
      half_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      ucount_q   <= ucount_d;
`ifdef WAV_FETCH_MONO_EN
      mono_q     <= mono_d;
      half_q     <= half_d;
`endif
    end
  end

  assign file_data_read = read_q;
  assign left_sample    = left_q;
  assign right_sample   = right_q;
  assign sample_valid   = valid_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucount_q;
  assign fifo_level     = level_s;

endmodule

// File: tb/tb_wav_sample_fetcher.sv
// Self-checking bench for wav_sample_fetcher: directed scenarios plus random
// traffic against a transaction-level model (word queue + bus handshake rules).
module tb_wav_sample_fetcher;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n, en, fl, wr, tk;
  logic [31:0] rdata;
  logic        rd_req;
  logic [15:0] left_s, right_s, ucount;
  logic        valid, uflag;
  logic [4:0]  level;
`ifdef WAV_FETCH_MONO_EN
  logic        mono = 1'b0;
`endif

  always #5 clk = ~clk;

  wav_sample_fetcher dut (
    .clk_clk               (clk),
    .reset_reset_n         (rst_n),
    .enable                (en),
    .flush                 (fl),
    .file_data_read        (rd_req),
    .file_data_readdata    (rdata),
    .file_data_waitrequest (wr),
    .sample_tick           (tk),
`ifdef WAV_FETCH_MONO_EN
    .mono_mode             (mono),
`endif
    .left_sample           (left_s),
    .right_sample          (right_s),
    .sample_valid          (valid),
    .underrun              (uflag),
    .underrun_count        (ucount),
    .fifo_level            (level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_read, m_disc, m_valid, m_uflag;
  logic [15:0] m_left, m_right, m_ucnt;
  bit          model_on = 1'b1;
  int          accepted = 0;

  task automatic step(input bit r_n, input bit e, input bit f, input bit w,
                      input logic [31:0] d, input bit t);
    int sz;
    bit xfer, pop_ok, under;
    rst_n = r_n; en = e; fl = f; wr = w; rdata = d; tk = t;
    if (rd_req && !w && r_n) accepted++;
    @(posedge clk);
    sz     = m_q.size();
    xfer   = m_read && !w;
    pop_ok = t && e && !f && (sz > 0);
    under  = t && e && !f && (sz == 0);
    if (!r_n) begin
      m_q.delete();
      m_read = 0; m_disc = 0; m_valid = 0; m_uflag = 0;
      m_left = 16'd0; m_right = 16'd0; m_ucnt = 16'd0;
    end else begin
      if (t) begin
        m_valid = 1; m_left = 16'd0; m_right = 16'd0;
        if (pop_ok) begin
          m_left  = m_q[0][15:0];
          m_right = m_q[0][31:16];
          void'(m_q.pop_front());
        end
      end else begin
        m_valid = 0;
      end
      if (under) begin
        m_uflag = 1;
        if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
      end
      if (xfer && !m_disc && !f) m_q.push_back(d);
      if (f) begin
        m_q.delete(); m_uflag = 0; m_ucnt = 16'd0;
      end
      if (m_read && !xfer) begin
        m_disc = m_disc || f;
      end else if (m_read) begin
        m_read = !m_disc && !f && e && (m_q.size() < DEPTH);
        m_disc = 0;
      end else begin
        m_read = e && !f && (sz < DEPTH);
        m_disc = 0;
      end
    end
    @(negedge clk);
    if (model_on) begin
      check_eq("read",   32'(rd_req),  32'(m_read));
      check_eq("level",  32'(level),   32'(m_q.size()));
      check_eq("valid",  32'(valid),   32'(m_valid));
      check_eq("left",   32'(left_s),  32'(m_left));
      check_eq("right",  32'(right_s), 32'(m_right));
      check_eq("uflag",  32'(uflag),   32'(m_uflag));
      check_eq("ucount", 32'(ucount),  32'(m_ucnt));
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; fl = 1'b0; wr = 1'b1; rdata = 32'd0; tk = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    check_eq("rst_read", 32'(rd_req), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_ucount", 32'(ucount), 32'd0);

    // Fill with no ticks: exactly DEPTH transfers
    accepted = 0;
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b0, 1'b0, $urandom, 1'b0);
    check_eq("fill_reads", 32'(accepted), 32'd16);
    check_eq("fill_level", 32'(level), 32'd16);
    check_eq("fill_read_low", 32'(rd_req), 32'd0);

    // Wait-state pattern, read held through waits
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check_eq("wait_read_held", 32'(rd_req), 32'd1);
      end
      step(1'b1, (k == 0), 1'b0, 1'b0, 32'hFFFE_0001, 1'b0);
    end
    check_eq("wait_level", 32'(level), 32'd2);
    check_eq("wait_valid_before", 32'(valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
    check_eq("wait_left", 32'(left_s), 32'h0001);
    check_eq("wait_right", 32'(right_s), 32'hFFFE);
    check_eq("wait_valid", 32'(valid), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
    check_eq("wait_valid_pulse", 32'(valid), 32'd0);
    check_eq("wait_left_hold", 32'(left_s), 32'h0001);

    // Underrun on empty FIFO, then saturation and flush
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
      check_eq("ur_valid", 32'(valid), 32'd1);
      check_eq("ur_left_zero", 32'(left_s), 32'd0);
    end
    check_eq("ur_flag", 32'(uflag), 32'd1);
    check_eq("ur_count3", 32'(ucount), 32'd3);
    for (int i = 0; i < 65537; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
    check_eq("ur_saturate", 32'(ucount), 32'hFFFF);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0);
    check_eq("ur_flush_count", 32'(ucount), 32'd0);
    check_eq("ur_flush_flag", 32'(uflag), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Flush during a stalled fetch: word discarded
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    check_eq("disc_read_held0", 32'(rd_req), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
      check_eq("disc_read_held", 32'(rd_req), 32'd1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
    check_eq("disc_level", 32'(level), 32'd0);
    check_eq("disc_read_low", 32'(rd_req), 32'd0);
    check_eq("disc_valid", 32'(valid), 32'd0);
    check_eq("disc_left", 32'(left_s), 32'd0);

    // Random traffic: fill-biased then drain-biased
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
           $urandom, (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

`ifdef WAV_FETCH_MONO_EN
    // Mono mode: two samples per word, pop on second tick
    model_on = 1'b0;
    mono = 1'b1;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0200_0100, 1'b0);
    check_eq("mono_level1", 32'(level), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
    check_eq("mono_l0", 32'(left_s), 32'h0100);
    check_eq("mono_r0", 32'(right_s), 32'h0100);
    check_eq("mono_level_hold", 32'(level), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
    check_eq("mono_l1", 32'(left_s), 32'h0200);
    check_eq("mono_r1", 32'(right_s), 32'h0200);
    check_eq("mono_level0", 32'(level), 32'd0);
    check_eq("mono_no_ur", 32'(uflag), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
